// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the seven-segment display sequencer.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StCommit
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int unsigned DEFAULT_NUM_DIGITS = 6;

endpackage

// File: rtl/hexdigit.sv
// Combinational hex-to-seven-segment decoder, active-low outputs, bit 0 = a .. bit 6 = g.
module hexdigit (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Seven-segment bank sequencer: decodes one digit per cycle through a shared decoder into a
// shadow buffer, commits all digits at once, and overlays per-digit blinking.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEFAULT_NUM_DIGITS,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [NUM_DIGITS-1:0]   load_blank,
    input  logic [NUM_DIGITS-1:0]   load_blink,
    input  logic                    load_lz,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    busy,
    output logic                    update_done
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(NUM_DIGITS - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

    state_e state_q, state_d;

    logic [NUM_DIGITS-1:0][3:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]      blank_q, blank_d;
    logic [NUM_DIGITS-1:0]      blink_q, blink_d;
    logic [NUM_DIGITS-1:0]      active_blink_q, active_blink_d;
    logic                       lz_q, lz_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic                       seen_nz_q, seen_nz_d;
    logic [NUM_DIGITS-1:0][6:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][6:0] display_q, display_d;
    logic                       update_done_q, update_done_d;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;

    logic [3:0] nibble;
    logic [6:0] dec_seg;
    logic       nibble_nz;
    logic       dark_now;

    assign nibble    = value_q[idx_q];
    assign nibble_nz = (nibble != 4'h0);

    hexdigit u_hexdigit (
        .value (nibble),
        .seg   (dec_seg)
    );

    // Digit 0 is exempt from leading-zero suppression so a zero value still shows "0".
    assign dark_now = blank_q[idx_q] ||
                      (lz_q && !seen_nz_q && !nibble_nz && (idx_q != '0));

    always_comb begin
        state_d        = state_q;
        value_d        = value_q;
        blank_d        = blank_q;
        blink_d        = blink_q;
        active_blink_d = active_blink_q;
        lz_d           = lz_q;
        idx_d          = idx_q;
        seen_nz_d      = seen_nz_q;
        shadow_d       = shadow_q;
        display_d      = display_q;
        update_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load_valid) begin
                    value_d   = load_value;
                    blank_d   = load_blank;
                    blink_d   = load_blink;
                    lz_d      = load_lz;
                    idx_d     = IdxTop;
                    seen_nz_d = 1'b0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                shadow_d[idx_q] = dark_now ? SEG_BLANK : dec_seg;
                seen_nz_d       = seen_nz_q | nibble_nz;
                if (idx_q == '0) begin
                    state_d = StCommit;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StCommit: begin
                display_d      = shadow_q;
                active_blink_d = blink_q;
                update_done_d  = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            value_q        <= '0;
            blank_q        <= '0;
            blink_q        <= '0;
            active_blink_q <= '0;
            lz_q           <= 1'b0;
            idx_q          <= '0;
            seen_nz_q      <= 1'b0;
            shadow_q       <= {NUM_DIGITS{SEG_BLANK}};
            display_q      <= {NUM_DIGITS{SEG_BLANK}};
            update_done_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            value_q        <= value_d;
            blank_q        <= blank_d;
            blink_q        <= blink_d;
            active_blink_q <= active_blink_d;
            lz_q           <= lz_d;
            idx_q          <= idx_d;
            seen_nz_q      <= seen_nz_d;
            shadow_q       <= shadow_d;
            display_q      <= display_d;
            update_done_q  <= update_done_d;
        end
    end

    // Free-running blink timer, deliberately independent of the update FSM.
    always_comb begin
        cnt_d   = cnt_q + CntW'(1);
        phase_d = phase_q;
        if (cnt_q == CntMax) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        seg = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            seg[7*i +: 7] = (active_blink_q[i] && phase_q) ? SEG_BLANK : display_q[i];
        end
    end

    assign load_ready  = (state_q == StIdle);
    assign busy        = !load_ready;
    assign update_done = update_done_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: fixed vectors, corner sequences, random loads.
module tb_hex_display_ctrl;

    localparam int ND  = 6;
    localparam int BDV = 4;

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [41:0] ALL_DARK = 42'h3FF_FFFF_FFFF;

    logic          clk;
    logic          rst_n;
    logic          load_valid;
    logic          load_ready;
    logic [23:0]   load_value;
    logic [5:0]    load_blank;
    logic [5:0]    load_blink;
    logic          load_lz;
    logic [41:0]   seg;
    logic          busy;
    logic          update_done;

    hex_display_ctrl #(
        .NUM_DIGITS (ND),
        .BLINK_DIV  (BDV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .load_blank  (load_blank),
        .load_blink  (load_blink),
        .load_lz     (load_lz),
        .seg         (seg),
        .busy        (busy),
        .update_done (update_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Edges since the last reset edge; the blink phase follows from this alone.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [41:0] exp_disp;
    logic [5:0]  exp_blink;

    typedef struct {
        logic [23:0] value;
        logic [5:0]  blank;
        logic        lz;
        logic [41:0] expect_seg;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [41:0] model_disp(input logic [23:0] v, input logic [5:0] b,
                                               input logic lz);
        logic [41:0] r;
        logic [23:0] upper;
        logic [3:0]  nib;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            upper = v >> (4 * i);
            nib   = upper[3:0];
            if (b[i] || (lz && i != 0 && upper == 24'h0)) r[7*i +: 7] = 7'h7F;
            else                                          r[7*i +: 7] = FONT[nib];
        end
        return r;
    endfunction

    function automatic logic [41:0] seg_expect();
        logic [41:0] r;
        int          phase;
        phase = (cyc / BDV) % 2;
        r = exp_disp;
        for (int i = 0; i < ND; i++) begin
            if (exp_blink[i] && phase == 1) r[7*i +: 7] = 7'h7F;
        end
        return r;
    endfunction

    task automatic do_load(input logic [23:0] v, input logic [5:0] b, input logic [5:0] bl,
                           input logic lz);
        int guard;
        int early;
        guard = 0;
        while (!load_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_load", 64'(load_ready), 64'd1);
        load_value = v;
        load_blank = b;
        load_blink = bl;
        load_lz    = lz;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        early = 0;
        for (int k = 1; k <= ND; k++) begin
            @(negedge clk);
            if (update_done) early++;
        end
        @(negedge clk);
        check("no_early_done", 64'(early), 64'd0);
        check("done_pulse", 64'(update_done), 64'd1);
        check("ready_after_commit", 64'(load_ready), 64'd1);
        exp_disp  = model_disp(v, b, lz);
        exp_blink = bl;
        check("seg_after_commit", 64'(seg), 64'(seg_expect()));
        @(negedge clk);
        check("done_one_cycle", 64'(update_done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tab[7];

    initial begin
        int          pulses;
        int          drop;
        int          saw_dark;
        int          saw_lit;
        logic [23:0] rv;
        logic [5:0]  rb;
        logic [5:0]  rbl;
        logic        rlz;

        tab[0] = '{24'h12AB0F, 6'b000000, 1'b0,
                   {7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E}};
        tab[1] = '{24'h000305, 6'b000000, 1'b1,
                   {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12}};
        tab[2] = '{24'h000000, 6'b000000, 1'b1,
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tab[3] = '{24'h12AB0F, 6'b100001, 1'b0,
                   {7'h7F, 7'h24, 7'h08, 7'h03, 7'h40, 7'h7F}};
        tab[4] = '{24'h000305, 6'b000000, 1'b0,
                   {7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h12}};
        tab[5] = '{24'h00A000, 6'b000100, 1'b1,
                   {7'h7F, 7'h7F, 7'h08, 7'h7F, 7'h40, 7'h40}};
        tab[6] = '{24'h100000, 6'b100000, 1'b1,
                   {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_value = '0;
        load_blank = '0;
        load_blink = '0;
        load_lz    = 1'b0;
        exp_disp   = ALL_DARK;
        exp_blink  = '0;
        repeat (3) @(negedge clk);
        check("reset_seg", 64'(seg), 64'(ALL_DARK));
        check("reset_done", 64'(update_done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(load_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (update_done) pulses++;
            check("idle_seg", 64'(seg), 64'(ALL_DARK));
        end
        check("idle_no_done", 64'(pulses), 64'd0);

        for (int i = 0; i < 7; i++) begin
            do_load(tab[i].value, tab[i].blank, 6'b0, tab[i].lz);
            check("table_seg", 64'(seg), 64'(tab[i].expect_seg));
        end

        // Digit 0 blinks; the other digits must hold steady.
        do_load(24'h12AB0F, 6'b0, 6'b000001, 1'b0);
        saw_dark = 0;
        saw_lit  = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("blink_seg", 64'(seg), 64'(seg_expect()));
            check("blink_steady", 64'(seg[41:7]), 64'({7'h79, 7'h24, 7'h08, 7'h03, 7'h40}));
            if (seg[6:0] == 7'h7F) saw_dark++;
            if (seg[6:0] == 7'h0E) saw_lit++;
        end
        check("blink_saw_dark", 64'(saw_dark), 64'd8);
        check("blink_saw_lit", 64'(saw_lit), 64'd8);

        // Second request held through the scan of the first one.
        load_value = 24'h123456;
        load_blank = '0;
        load_blink = '0;
        load_lz    = 1'b0;
        load_valid = 1'b1;
        @(negedge clk);
        load_value = 24'h0000F0;
        load_lz    = 1'b1;
        pulses = 0;
        drop   = 0;
        exp_blink = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (drop == 1) load_valid = 1'b0;
            if (update_done) begin
                pulses++;
                if (pulses == 1) begin
                    exp_disp = model_disp(24'h123456, 6'b0, 1'b0);
                    check("hold_first_seg", 64'(seg), 64'(exp_disp));
                end
            end
            if (k < ND && !update_done) check("hold_not_ready", 64'(load_ready), 64'd0);
            if (load_ready && load_valid && pulses == 1) drop = 1;
        end
        load_valid = 1'b0;
        check("hold_two_pulses", 64'(pulses), 64'd2);
        exp_disp = model_disp(24'h0000F0, 6'b0, 1'b1);
        check("hold_final_seg", 64'(seg), 64'(seg_expect()));

        // Reset during the third scan cycle aborts the update.
        load_value = 24'h654321;
        load_blank = '0;
        load_blink = 6'b111111;
        load_lz    = 1'b0;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_seg", 64'(seg), 64'(ALL_DARK));
        check("abort_done", 64'(update_done), 64'd0);
        check("abort_ready", 64'(load_ready), 64'd1);
        rst_n     = 1'b1;
        exp_disp  = ALL_DARK;
        exp_blink = '0;
        pulses    = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (update_done) pulses++;
            check("abort_idle_seg", 64'(seg), 64'(ALL_DARK));
        end
        check("abort_no_done", 64'(pulses), 64'd0);

        for (int n = 0; n < 30; n++) begin
            rv  = 24'($urandom) >> (4 * $urandom_range(0, 6));
            rb  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            rbl = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
            rlz = 1'($urandom);
            do_load(rv, rb, rbl, rlz);
            for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
                @(negedge clk);
                check("rand_idle_seg", 64'(seg), 64'(seg_expect()));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
